// File: rtl/pqc_issue_ctrl.sv
// PQC issue controller: sits between the RV64 EX stage and the multi-cycle
// PQC coprocessor. Detects PQC custom ops, stalls EX, runs the req/gnt/done
// handshake and returns a single writeback beat. Handles flush, illegal
// funct7 and a coprocessor timeout.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no op in flight; watching EX for a PQC op
// ISSUE | cop_req held high with latched fields until cop_gnt
// BUSY  | coprocessor working; counting toward TIMEOUT, waiting for cop_done
// WB    | one cycle: writeback beat (unless killed or rd==0), EX released
module pqc_issue_ctrl #(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 11
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic [31:0]     ex_inst,
   input  logic [XLEN-1:0] ex_op_a,
   input  logic [XLEN-1:0] ex_op_b,
   input  logic            flush,
   output logic            stall_o,
   output logic            cop_req,
   output logic [6:0]      cop_funct7,
   output logic [XLEN-1:0] cop_op_a,
   output logic [XLEN-1:0] cop_op_b,
   input  logic            cop_gnt,
   input  logic            cop_done,
   input  logic [XLEN-1:0] cop_result,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            illegal_o,
   output logic            timeout_o
);

   localparam logic [6:0]       PQC_OPCODE = 7'b0001011;
   localparam logic [2:0]       PQC_FUNCT3 = 3'b011;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, WB} state_t;

   state_t           state;
   logic             killed;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       rd_q;

   logic       is_pqc;
   logic       hit;
   logic       legal;
   logic [6:0] funct7;
   logic       unused_inst;

   assign funct7      = ex_inst[31:25];
   assign is_pqc      = (ex_inst[6:0] == PQC_OPCODE) && (ex_inst[14:12] == PQC_FUNCT3);
   assign hit         = ex_valid & is_pqc & ~flush;
   assign unused_inst = ^ex_inst[24:15];

   // decode the supported funct7 values
   always_comb begin
      legal = 1'b0;
      case (funct7)
         7'd0, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7: legal = 1'b1;
         default:                            legal = 1'b0;
      endcase
   end

   // Stall is combinational so EX is held in the detect cycle itself. Once the
   // in-flight op is killed, EX is only held again if a new PQC op shows up.
   // Gated by rst_n so reset forces every output low without a clock edge.
   always_comb begin
      stall_o = 1'b0;
      if (rst_n) begin
         stall_o = ((state == IDLE) & hit & legal) |
                   (((state == ISSUE) | (state == BUSY)) & (~killed | hit));
      end
   end

   // sequencer FSM with registered handshake, writeback and pulse outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         killed     <= 1'b0;
         cnt        <= '0;
         rd_q       <= '0;
         cop_req    <= 1'b0;
         cop_funct7 <= '0;
         cop_op_a   <= '0;
         cop_op_b   <= '0;
         wb_valid   <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         illegal_o  <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         illegal_o <= 1'b0;
         timeout_o <= 1'b0;
         wb_valid  <= 1'b0;
         case (state)
            IDLE: begin
               killed <= 1'b0;
               if (hit && legal) begin
                  cop_funct7 <= funct7;
                  cop_op_a   <= ex_op_a;
                  cop_op_b   <= ex_op_b;
                  rd_q       <= ex_inst[11:7];
                  cop_req    <= 1'b1;
                  state      <= ISSUE;
               end else if (hit) begin
                  illegal_o <= 1'b1;
               end
            end
            ISSUE: begin
               // request is never withdrawn before gnt, a flush only marks the op
               killed <= killed | flush;
               if (cop_gnt) begin
                  cop_req <= 1'b0;
                  cnt     <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + CNT_W'(1);
               if (cop_done) begin
                  // a flush in the done cycle still suppresses the beat
                  wb_data  <= cop_result;
                  wb_rd    <= rd_q;
                  wb_valid <= ~(killed | flush) & (rd_q != 5'd0);
                  killed   <= killed | flush;
                  state    <= WB;
               end else if (cnt == CNT_LAST) begin
                  timeout_o <= 1'b1;
                  killed    <= 1'b0;
                  state     <= IDLE;
               end else begin
                  killed <= killed | flush;
               end
            end
            WB: begin
               killed <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pqc_issue_ctrl.sv
// Bench for pqc_issue_ctrl: table of single-op vectors plus hand-written
// sequences for flush, same-cycle flush and async reset. Expected writeback
// beats are queued when an op is driven and popped when wb_valid appears.
module tb_pqc_issue_ctrl;

   localparam int XLEN = 64;
   localparam int TO   = 8;

   logic            clk;
   logic            rst_n;
   logic            ex_valid;
   logic [31:0]     ex_inst;
   logic [XLEN-1:0] ex_op_a;
   logic [XLEN-1:0] ex_op_b;
   logic            flush;
   logic            stall_o;
   logic            cop_req;
   logic [6:0]      cop_funct7;
   logic [XLEN-1:0] cop_op_a;
   logic [XLEN-1:0] cop_op_b;
   logic            cop_gnt;
   logic            cop_done;
   logic [XLEN-1:0] cop_result;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            illegal_o;
   logic            timeout_o;

   pqc_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TO), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_inst(ex_inst),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .flush(flush), .stall_o(stall_o),
      .cop_req(cop_req), .cop_funct7(cop_funct7), .cop_op_a(cop_op_a),
      .cop_op_b(cop_op_b), .cop_gnt(cop_gnt), .cop_done(cop_done),
      .cop_result(cop_result), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .illegal_o(illegal_o), .timeout_o(timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_t;
   wb_t sb_q[$];

   typedef struct {
      logic [6:0]      f7;
      logic [2:0]      f3;
      logic [4:0]      rd;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] res;
      int              gnt_dly;
      int              done_cyc;   // BUSY cycle index carrying cop_done, -1 = never
      bit              exp_legal;
      bit              exp_ill;
      bit              exp_wb;
      bit              exp_to;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, 7'b0001011};
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"},   stall_o,    0);
      chk({tag, "_req"},     cop_req,    0);
      chk({tag, "_funct7"},  cop_funct7, 0);
      chk({tag, "_op_a"},    cop_op_a,   0);
      chk({tag, "_op_b"},    cop_op_b,   0);
      chk({tag, "_wbv"},     wb_valid,   0);
      chk({tag, "_wbrd"},    wb_rd,      0);
      chk({tag, "_wbdata"},  wb_data,    0);
      chk({tag, "_illegal"}, illegal_o,  0);
      chk({tag, "_timeout"}, timeout_o,  0);
   endtask

   // scoreboard: every writeback beat must match the oldest expected entry
   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_wb: got rd=%0d data=0x%0h expected no beat", wb_rd, wb_data);
         end else begin
            wb_t e;
            e = sb_q.pop_front();
            if (wb_rd !== e.rd || wb_data !== e.data) begin
               bad++;
               $display("FAIL sb_wb: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                        wb_rd, wb_data, e.rd, e.data);
            end
         end
      end
   end

   task automatic idle_inputs();
      ex_valid = 0; ex_inst = '0; ex_op_a = '0; ex_op_b = '0; flush = 0;
      cop_gnt = 0; cop_done = 0; cop_result = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int    nstall;
      int    exp_n;
      string t;
      t = $sformatf("v%0d", idx);
      ex_valid = 1; ex_inst = mk_inst(v.f7, v.f3, v.rd);
      ex_op_a = v.a; ex_op_b = v.b; flush = 0; cop_gnt = 0; cop_done = 0;
      @(negedge clk);
      chk({t, "_stall_detect"}, stall_o, v.exp_legal);
      if (!v.exp_legal) begin
         @(posedge clk); #1 ex_valid = 0;
         @(negedge clk);
         chk({t, "_illegal"}, illegal_o, v.exp_ill);
         chk({t, "_ill_req"}, cop_req, 0);
         chk({t, "_ill_stall"}, stall_o, 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk({t, "_ill_once"}, illegal_o, 0);
         chk({t, "_ill_req2"}, cop_req, 0);
         return;
      end
      if (v.exp_wb) sb_q.push_back('{rd: v.rd, data: v.res});
      nstall = stall_o ? 1 : 0;
      // ISSUE: stray done before gnt must be ignored
      for (int i = 0; i <= v.gnt_dly; i++) begin
         @(posedge clk); #1;
         cop_gnt    = (i == v.gnt_dly);
         cop_done   = (i != v.gnt_dly);
         cop_result = ~v.res;
         @(negedge clk);
         chk({t, "_req"},    cop_req,    1);
         chk({t, "_funct7"}, cop_funct7, v.f7);
         chk({t, "_op_a"},   cop_op_a,   v.a);
         chk({t, "_op_b"},   cop_op_b,   v.b);
         if (stall_o) nstall++;
      end
      // BUSY: stray gnt must be ignored
      for (int i = 0; i < TO; i++) begin
         @(posedge clk); #1;
         cop_gnt    = 1;
         cop_done   = (i == v.done_cyc);
         cop_result = (i == v.done_cyc) ? v.res : '0;
         @(negedge clk);
         chk({t, "_busy_req"}, cop_req, 0);
         if (stall_o) nstall++;
         if (i == v.done_cyc) break;
      end
      @(posedge clk); #1;
      cop_gnt = 0; cop_done = 0; cop_result = '0;
      if (v.exp_to) ex_valid = 0;
      @(negedge clk);
      chk({t, "_timeout"}, timeout_o, v.exp_to);
      chk({t, "_wbv"}, wb_valid, v.exp_wb);
      chk({t, "_stall_end"}, stall_o, 0);
      exp_n = v.exp_to ? (2 + v.gnt_dly + TO) : (3 + v.gnt_dly + v.done_cyc);
      chk({t, "_stall_cycles"}, nstall, exp_n);
      @(posedge clk); #1 ex_valid = 0;
      @(negedge clk);
      chk({t, "_wbv_once"}, wb_valid, 0);
      chk({t, "_to_once"}, timeout_o, 0);
      chk({t, "_idle_req"}, cop_req, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{7'd3, 3'b011, 5'd5, 64'h11, 64'h22, 64'hABCD, 0, 3, 1, 0, 1, 0};
      vecs[1] = '{7'd0, 3'b011, 5'd1, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF,
                  64'hFFFF_0000_1234_5678, 3, 0, 1, 0, 1, 0};
      vecs[2] = '{7'd7, 3'b011, 5'd31, 64'h7, 64'h9, 64'h8000_0000_0000_0001, 1, TO - 1, 1, 0, 1, 0};
      vecs[3] = '{7'd2, 3'b011, 5'd4, 64'h1, 64'h2, 64'h0, 0, 0, 0, 1, 0, 0};
      vecs[4] = '{7'd1, 3'b011, 5'd4, 64'h1, 64'h2, 64'h0, 0, 0, 0, 1, 0, 0};
      vecs[5] = '{7'h40, 3'b011, 5'd4, 64'h1, 64'h2, 64'h0, 0, 0, 0, 1, 0, 0};
      vecs[6] = '{7'd3, 3'b010, 5'd4, 64'h1, 64'h2, 64'h0, 0, 0, 0, 0, 0, 0};
      vecs[7] = '{7'd4, 3'b011, 5'd0, 64'h3, 64'h4, 64'h5555, 0, 1, 1, 0, 0, 0};
      vecs[8] = '{7'd5, 3'b011, 5'd9, 64'hA, 64'hB, 64'h6666, 2, -1, 1, 0, 0, 1};
      vecs[9] = '{7'd6, 3'b011, 5'd12, 64'hC, 64'hD, 64'h0F0F_F0F0_1234_4321, 0, 6, 1, 0, 1, 0};

      idle_inputs();
      rst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1 rst_n = 1;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // flush in the detect cycle: nothing issues
      ex_valid = 1; ex_inst = mk_inst(7'd3, 3'b011, 5'd6); flush = 1;
      @(negedge clk);
      chk("sameflush_stall", stall_o, 0);
      @(posedge clk); #1 ex_valid = 0; flush = 0;
      @(negedge clk);
      chk("sameflush_req", cop_req, 0);
      chk("sameflush_ill", illegal_o, 0);

      // flush two cycles into BUSY, then a second op arrives while killed op finishes
      @(posedge clk); #1;
      ex_valid = 1; ex_inst = mk_inst(7'd3, 3'b011, 5'd7); ex_op_a = 64'h71; ex_op_b = 64'h72;
      @(negedge clk);
      chk("fl_stall_detect", stall_o, 1);
      @(posedge clk); #1 cop_gnt = 1;
      @(negedge clk);
      chk("fl_req", cop_req, 1);
      @(posedge clk); #1 cop_gnt = 0;
      @(posedge clk); #1;
      @(posedge clk); #1 flush = 1;
      @(negedge clk);
      chk("fl_stall_flushcyc", stall_o, 1);
      @(posedge clk); #1 flush = 0; ex_valid = 0;
      @(negedge clk);
      chk("fl_stall_after", stall_o, 0);
      @(posedge clk); #1;
      ex_valid = 1; ex_inst = mk_inst(7'd6, 3'b011, 5'd8); ex_op_a = 64'h81; ex_op_b = 64'h82;
      @(negedge clk);
      chk("fl_stall_2nd_hit", stall_o, 1);
      chk("fl_funct7_held", cop_funct7, 7'd3);
      @(posedge clk); #1 cop_done = 1; cop_result = 64'h55;
      @(negedge clk);
      chk("fl_stall_done", stall_o, 1);
      @(posedge clk); #1 cop_done = 0; cop_result = '0;
      @(negedge clk);
      chk("fl_killed_wbv", wb_valid, 0);
      sb_q.push_back('{rd: 5'd8, data: 64'h8888_0000_0000_0008});
      @(posedge clk); #1;
      @(negedge clk);
      chk("fl2_stall_idle", stall_o, 1);
      @(posedge clk); #1 cop_gnt = 1;
      @(negedge clk);
      chk("fl2_req", cop_req, 1);
      chk("fl2_funct7", cop_funct7, 7'd6);
      chk("fl2_op_a", cop_op_a, 64'h81);
      @(posedge clk); #1 cop_gnt = 0; cop_done = 1; cop_result = 64'h8888_0000_0000_0008;
      @(posedge clk); #1 cop_done = 0; cop_result = '0;
      @(negedge clk);
      chk("fl2_wbv", wb_valid, 1);
      chk("fl2_wbrd", wb_rd, 5'd8);
      @(posedge clk); #1 ex_valid = 0;

      // async reset while BUSY with the op still sitting in EX
      @(posedge clk); #1;
      ex_valid = 1; ex_inst = mk_inst(7'd3, 3'b011, 5'd3); ex_op_a = 64'h31; ex_op_b = 64'h32;
      @(posedge clk); #1 cop_gnt = 1;
      @(posedge clk); #1 cop_gnt = 0;
      @(negedge clk);
      chk("rst_pre_stall", stall_o, 1);
      #2 rst_n = 0;
      #1 chk_all_zero("async_rst");
      @(posedge clk); #1 idle_inputs();
      rst_n = 1;
      @(negedge clk);
      chk("post_rst_req", cop_req, 0);
      chk("post_rst_stall", stall_o, 0);

      repeat (2) @(posedge clk);
      chk("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
